// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch sequencer state encoding, reset PC and statistics width.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_UPDATE = 2'd3
  } br_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int unsigned STAT_W           = 16;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target: pc plus sign-extended offset, wrapping modulo 2^32. Purely combinational.
module branch_target_adder #(
  parameter int IMM_W = 19
) (
  input  logic [31:0]      pc,
  input  logic [IMM_W-1:0] offset,
  output logic [31:0]      target
);

  logic [31:0] offset_sx;

  assign offset_sx = {{(32-IMM_W){offset[IMM_W-1]}}, offset};
  assign target    = pc + offset_sx;

endmodule

// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer: IDLE->EVAL->SETTLE->UPDATE, start-to-done 4 cycles, start ignored while busy.
// Optional taken/not-taken saturating counters when BRANCH_STATS_EN is defined.
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IMM_W    = 19
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] instruction,
  input  logic        start,
  input  logic        pc_inc,
  input  logic        pc_load,
  input  logic [31:0] pc_data,
  input  logic        con_output,
  output logic        con_enable,
  output logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic        taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] taken_cnt,
  output logic [STAT_W-1:0] not_taken_cnt
`endif
);

  br_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [IMM_W-1:0] offset_q, offset_d;
  logic             con_enable_q, con_enable_d;
  logic             done_q, done_d;
  logic             taken_q, taken_d;
  logic [31:0]      target;
  logic             unused_ir;

  // Only the offset field of the IR matters here.
  assign unused_ir = ^instruction[31:IMM_W];

  branch_target_adder #(
    .IMM_W (IMM_W)
  ) u_target (
    .pc     (pc_q),
    .offset (offset_q),
    .target (target)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    offset_d     = offset_q;
    con_enable_d = 1'b0;
    done_d       = 1'b0;
    taken_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_EVAL;
          // Registered so the CON strobe is a clean flop output during EVAL.
          con_enable_d = 1'b1;
        end else if (pc_load) begin
          pc_d = pc_data;
        end else if (pc_inc) begin
          pc_d = pc_q + 32'd1;
        end
      end
      ST_EVAL: begin
        state_d  = ST_SETTLE;
        offset_d = instruction[IMM_W-1:0];
      end
      ST_SETTLE: begin
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        taken_d = con_output;
        if (con_output) begin
          pc_d = target;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= ST_IDLE;
      pc_q         <= PC_RESET;
      offset_q     <= '0;
      con_enable_q <= 1'b0;
      done_q       <= 1'b0;
      taken_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      offset_q     <= offset_d;
      con_enable_q <= con_enable_d;
      done_q       <= done_d;
      taken_q      <= taken_d;
    end
  end

  assign con_enable = con_enable_q;
  assign pc         = pc_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign taken      = taken_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [STAT_W-1:0] not_taken_cnt_q, not_taken_cnt_d;

  always_comb begin
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    if (state_q == ST_UPDATE) begin
      if (con_output) begin
        if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 1'b1;
      end else begin
        if (not_taken_cnt_q != '1) not_taken_cnt_d = not_taken_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule
